// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers hex digits from a scanned active-low 7-segment bus
module sevenseg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  update
);
  localparam int W = DIGITS + 7;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
  state_t state, state_nxt;
  logic [W-1:0] sync1, sync2, prev;
  logic [7:0] cnt, cnt_nxt;
  logic [DIGITS-1:0] sel;
  logic chg, one_sel, cap, legal;
  logic [3:0] nib;
  assign sel = ~sync2[W-1:7];
  assign one_sel = $countones(sel) == 1;
  assign chg = sync2 != prev;
  assign cnt_nxt = chg ? 8'd1 : (cnt == STABLE ? cnt : cnt + 8'd1);
  // synchronize {an, seg}, remember the previous sample and count how long it has been stable
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      cnt   <= '0;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_nxt;
    end
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // next state; capture fires once per stable run of a single selected digit
  always_comb begin
    state_nxt = state;
    cap = 1'b0;
    case (state)
      IDLE:  state_nxt = one_sel ? TRACK : IDLE;
      TRACK: if (!one_sel) state_nxt = IDLE;
             else if (!chg && cnt_nxt == STABLE) begin
               cap = 1'b1;
               state_nxt = HOLD;
             end
      HOLD:  if (chg) state_nxt = one_sel ? TRACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // segment pattern back to nibble; anything outside the encoder's table is illegal
  always_comb begin
    nib = 4'h0;
    legal = 1'b1;
    case (sync2[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // capture into the selected digit only; an error set on the same edge beats err_clr
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      hex_out     <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      update      <= 1'b0;
    end else begin
      update    <= cap;
      digit_err <= (err_clr ? '0 : digit_err) | (cap && !legal ? sel : '0);
      for (int i = 0; i < DIGITS; i++)
        if (cap && sel[i]) begin
          digit_valid[i] <= legal;
          if (legal) hex_out[4*i +: 4] <= nib;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder: random and directed checks against a run-length reference model
module tb_sevenseg_scan_decoder;
  localparam int D = 4;
  localparam int S = 4;
  localparam int W = D + 7;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic err_clr = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [D-1:0] an = '1;
  logic [4*D-1:0] hex_out;
  logic [D-1:0] digit_valid, digit_err;
  logic update;
  sevenseg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clock(clock), .resetn(resetn), .seg(seg), .an(an), .err_clr(err_clr),
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_err(digit_err), .update(update)
  );
  always #5 clock = ~clock;
  int errors = 0;
  int checks = 0;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [W-1:0] hist[$];
  logic [W-1:0] last;
  int run, edge_n, upd_cnt, upd_edge, base;
  logic [4*D-1:0] e_hex;
  logic [D-1:0] e_val, e_err;
  logic e_upd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist = '{{W{1'b1}}, {W{1'b1}}};
    last = '1;
    run = 0;
    e_hex = '0;
    e_val = '0;
    e_err = '0;
    e_upd = 1'b0;
  endtask
  // one clock edge: the pins seen two edges ago form the sample; a run of S identical
  // samples with exactly one digit selected captures exactly once
  task automatic step();
    logic [W-1:0] smp;
    logic [D-1:0] m;
    int hit;
    @(posedge clock);
    edge_n++;
    if (!resetn) model_reset();
    else begin
      hist.push_back({an, seg});
      smp = hist.pop_front();
      run = (smp == last) ? run + 1 : 1;
      last = smp;
      e_upd = 1'b0;
      if (err_clr) e_err = '0;
      m = ~smp[W-1:7];
      if (run == S && $countones(m) == 1) begin
        e_upd = 1'b1;
        hit = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == smp[6:0]) hit = i;
        for (int d = 0; d < D; d++)
          if (m[d]) begin
            if (hit >= 0) begin
              e_hex[4*d +: 4] = 4'(hit);
              e_val[d] = 1'b1;
            end else begin
              e_val[d] = 1'b0;
              e_err[d] = 1'b1;
            end
          end
      end
    end
    #1;
    chk("update", {31'b0, update}, {31'b0, e_upd});
    chk("hex_out", 32'(hex_out), 32'(e_hex));
    chk("digit_valid", 32'(digit_valid), 32'(e_val));
    chk("digit_err", 32'(digit_err), 32'(e_err));
    if (update) begin
      upd_cnt++;
      upd_edge = edge_n;
    end
  endtask
  task automatic hold(input logic [D-1:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) step();
  endtask
  initial begin
    logic [D-1:0] ra;
    logic [6:0] rs;
    edge_n = 0;
    upd_cnt = 0;
    upd_edge = 0;
    model_reset();
    #1 resetn = 1'b0;
    #2;
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_update", {31'b0, update}, 32'h0);
    repeat (2) step();
    // 1: single digit capture latency and single pulse
    an = 4'b1110;
    seg = 7'h40;
    resetn = 1'b1;
    base = edge_n;
    upd_cnt = 0;
    repeat (12) step();
    chk("t1_latency", 32'(upd_edge - base), 32'd6);
    chk("t1_pulses", 32'(upd_cnt), 32'd1);
    chk("t1_nib", 32'(hex_out[3:0]), 32'h0);
    chk("t1_valid", 32'(digit_valid), 32'b0001);
    // 2: scan all digits
    upd_cnt = 0;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    chk("t2_hex", 32'(hex_out), 32'h4321);
    chk("t2_valid", 32'(digit_valid), 32'b1111);
    chk("t2_pulses", 32'(upd_cnt), 32'd4);
    // 3: blank digit is an error; err_clr clears it
    hold(4'b1101, 7'h7F, 8);
    chk("t3_err", 32'(digit_err), 32'b0010);
    chk("t3_valid1", {31'b0, digit_valid[1]}, 32'h0);
    chk("t3_nib1", 32'(hex_out[7:4]), 32'h2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_clr", 32'(digit_err), 32'h0);
    // 4: one-cycle glitches never capture
    upd_cnt = 0;
    repeat (6) begin
      hold(4'b1110, 7'h40, 2);
      hold(4'b1110, 7'h79, 1);
    end
    chk("t4_pulses", 32'(upd_cnt), 32'd0);
    chk("t4_hex", 32'(hex_out), 32'h4321);
    hold(4'b1110, 7'h0E, 8);
    chk("t4_nibF", 32'(hex_out[3:0]), 32'hF);
    // 5: zero or multiple digits selected never capture
    upd_cnt = 0;
    hold(4'b1100, 7'h08, 20);
    hold(4'b1111, 7'h08, 20);
    chk("t5_pulses", 32'(upd_cnt), 32'd0);
    chk("t5_hex", 32'(hex_out), 32'h432F);
    hold(4'b0111, 7'h08, 8);
    chk("t5_nibA", 32'(hex_out[15:12]), 32'hA);
    // 6: async reset mid-count
    hold(4'b1110, 7'h12, 4);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_hex", 32'(hex_out), 32'h0);
    chk("t6_valid", 32'(digit_valid), 32'h0);
    chk("t6_err", 32'(digit_err), 32'h0);
    step();
    resetn = 1'b1;
    base = edge_n;
    upd_cnt = 0;
    upd_edge = 0;
    repeat (10) step();
    chk("t6_latency", 32'(upd_edge - base), 32'd6);
    chk("t6_nib5", 32'(hex_out[3:0]), 32'h5);
    // random traffic
    repeat (250) begin
      ra = ($urandom_range(0, 3) == 0) ? D'($urandom) : ~(D'(1) << $urandom_range(0, D - 1));
      rs = ($urandom_range(0, 2) != 0) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      hold(ra, rs, $urandom_range(1, 8));
    end
    err_clr = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Recovers hex digits from a multiplexed, active-low 7-segment display bus, i.e. the segment patterns produced by our hex-to-7-segment encoding.
- Snoops the segment and digit-enable lines of a scanned display, waits for each digit's pattern to be stable, and decodes it back to a 4-bit nibble.
- Holds one nibble per digit with valid and error flags.
- Sits beside the display driver as a self-check and debug readback path.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (2..255).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seg  in  7  segment lines, active-low; bit0 = segment a … bit6 = segment g.
- an  in  DIGITS  digit enables, active-low; bit i selects digit i.
- err_clr  in  1  synchronous clear of sticky error flags.
- hex_out  out  4*DIGITS  decoded nibbles; hex_out[4i+3:4i] belongs to digit i.
- digit_valid  out  DIGITS  bit i = 1 when hex_out for digit i holds a legal decode.
- digit_err  out  DIGITS  sticky; bit i = 1 when digit i was captured with an illegal pattern.
- update  out  1  one-cycle pulse on every capture, legal or illegal.

Behaviour:
- Reset (resetn low, asynchronous): hex_out = 0, digit_valid = 0, digit_err = 0, update = 0, synchronizers = all-ones (blank, no digit), counter = 0, FSM = IDLE.
- Input path: {an, seg} pass through a 2-flop synchronizer. A "sample" is the second-flop value. A run counter (8 bit, saturating at STABLE_CYCLES) loads 1 when the sample differs from the previous sample, otherwise increments.
- Decode table (seg hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F. Any other pattern is illegal.
- FSM:
  - IDLE: sample has zero or more than one an bit low. No capture. Go to TRACK when exactly one bit is low.
  - TRACK: exactly one digit selected, counter < STABLE_CYCLES. When the counter reaches STABLE_CYCLES, do CAPTURE on that edge, then go to HOLD.
  - HOLD: pattern already captured. No further captures until the sample changes. On change, go to TRACK if exactly one bit is low, else IDLE.
- CAPTURE for selected digit i:
  - Legal pattern: hex_out[i] = nibble, digit_valid[i] = 1.
  - Illegal pattern: hex_out[i] unchanged, digit_valid[i] = 0, digit_err[i] = 1.
  - In both cases update = 1 for exactly the following cycle. Other digits are untouched.
- Latency: with pins held constant from rising edge 1 onward, the capture registers on edge 2+STABLE_CYCLES, and the outputs and update are visible after that edge.
- Glitches: any change in the sample before the count completes restarts the count at 1. A one-cycle glitch therefore never captures.
- err_clr = 1 clears all digit_err bits on the next edge. If a capture sets digit_err[i] on the same edge, the set wins for bit i.
- Blank digit (seg = 7F with a digit selected) is an illegal pattern.
- Consecutive identical scans of one digit recapture after each change of an, so update pulses once per scan visit.
- resetn asserted mid-count aborts the count and clears everything immediately. No capture occurs on release until a full new stable run.

Test Plan (DIGITS=4, STABLE_CYCLES=4):
1. Reset, then hold an=1110, seg=40 → update pulses once, 6 edges after the first sampling edge; hex_out[3:0]=0, digit_valid=0001; holding longer gives no second pulse.
2. Scan digits 0..3 with seg 79, 24, 30, 19, each held 8 cycles → hex_out=4321 (hex), digit_valid=1111, four update pulses.
3. an=1101, seg=7F held 8 cycles → digit_err=0010, digit_valid[1]=0, hex_out[7:4] unchanged; err_clr pulse → digit_err=0000.
4. an=1110, seg=40 with a 1-cycle glitch to 79 every 3 cycles → no update, outputs unchanged; then hold seg=0E → hex_out[3:0]=F.
5. an=1100 (two digits) or an=1111 held 20 cycles → no update, FSM stays IDLE; then an=0111, seg=08 → hex_out[15:12]=A.
6. Capture in progress, then resetn low for 1 cycle after 2 stable cycles → all outputs 0 at once; after release with inputs held, capture occurs 6 edges later.
